rsa_job_arbiter: RTL and testbench
==================================

RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 The module SHALL have parameter KEY_WIDTH, default 256, the engine key/modulus/data width in bits (multiple of 32).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum cycles from job load end to first engine output word.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester job request, bit i = requester i.
REQ-006 gnt  output  2  one-hot grant, held for the whole job.
REQ-007 in_data0, in_data1  input  32  requester word.
REQ-008 in_sel0, in_sel1  input  2  word type: 11 data, 01 modulus, 10 key (00 ignored).
REQ-009 in_valid0, in_valid1  input  1  word valid, honoured only while granted.
REQ-010 in_last0, in_last1  input  1  marks final word of the job.
REQ-011 eng_en  output  1  engine enable.
REQ-012 eng_data_in  output  32  word to engine.
REQ-013 eng_select  output  2  word type to engine.
REQ-014 eng_valid_in  output  1  engine load strobe.
REQ-015 eng_data_out  input  32  engine result word.
REQ-016 eng_valid_out  input  1  engine result valid.
REQ-017 out_data  output  32  result word, registered.
REQ-018 out_valid  output  1  result word valid.
REQ-019 out_id  output  1  requester that owns out_data.
REQ-020 done  output  1  one-cycle pulse at end of job.
REQ-021 err  output  1  one-cycle pulse on overflow or timeout.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, GAP, WAIT, DRAIN; reset state IDLE.
REQ-023 IDLE: if any req bit set, grant round-robin (priority to requester not granted last; requester 0 first after reset), go LOAD next cycle with gnt asserted.
REQ-024 LOAD: granted in_valid word SHALL be forwarded to eng_data_in/eng_select with eng_valid_in=1 one cycle later (1-cycle latency).
REQ-025 When in_sel differs from previous forwarded word's type, FSM SHALL go GAP for one cycle with eng_valid_in=0, then forward the held word; requester is not back-pressured (controller holds exactly one word).
REQ-026 A per-field word counter SHALL reset on each type change; words beyond KEY_WIDTH/32 in one field SHALL be dropped and err pulsed once.
REQ-027 Words with sel 00 SHALL be dropped silently.
REQ-028 After forwarding the in_last word, eng_valid_in SHALL drop to 0 and FSM go WAIT.
REQ-029 WAIT: on eng_valid_out=1 go DRAIN; each eng_valid_out cycle SHALL produce out_valid=1, out_data=eng_data_out, out_id=granted index one cycle later.
REQ-030 DRAIN: on first eng_valid_out=0, pulse done, clear gnt, return to IDLE; new grant no earlier than the following cycle.
REQ-031 req deassertion during LOAD/WAIT/DRAIN SHALL NOT abort the job.
REQ-032 eng_en SHALL be 1 in every state except reset; eng_data_in SHALL be 0 when eng_valid_in=0.
REQ-033 Requests from both requesters in the same cycle SHALL resolve by round-robin pointer only.

Reset
REQ-034 On rst: state IDLE, gnt=0, eng_en=0, eng_valid_in=0, eng_select=0, eng_data_in=0, out_valid=0, out_data=0, out_id=0, done=0, err=0, round-robin pointer favours requester 0, counters 0.
REQ-035 Reset mid-job SHALL abandon the job with no done pulse; engine output arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-036 Macro RSA_ARB_TIMEOUT_EN: when defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYCLES pulses err and done, clears gnt, returns IDLE. When undefined, WAIT waits indefinitely and no timeout logic exists.

Verification
REQ-037 req=01, requester 0 sends 1 modulus word 0x0000000D, 1 key word 0x00000005, 1 data word 0x00000002 (last) -> one GAP before key and data, out_data=0x00000006, out_id=0, done pulse.
REQ-038 req=11 same cycle after reset -> requester 0 granted first; second job after done grants requester 1.
REQ-039 Requester sends 9 modulus words with KEY_WIDTH=256 -> 9th dropped, err pulses once, job completes.
REQ-040 Job with only data words (no key/modulus), macro defined, TIMEOUT_CYCLES=16 -> err and done 16 cycles after WAIT entry, gnt cleared.
REQ-041 rst asserted during LOAD -> all outputs zero immediately, no done, next req granted normally.

Source files
------------

// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: grants one of two requesters access to a shared RSA engine.
// The arbiter forwards the winner's modulus/key/data words with a one-cycle bubble
// on every field change. It then returns the engine result words tagged with the
// requester index.
// Optional feature: define RSA_ARB_TIMEOUT_EN to abort a job whose engine does not
// answer within TIMEOUT_CYCLES of entering WAIT.
module rsa_job_arbiter #(
  parameter int unsigned KEY_WIDTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [31:0] in_data0,
  input  logic [31:0] in_data1,
  input  logic [1:0]  in_sel0,
  input  logic [1:0]  in_sel1,
  input  logic        in_valid0,
  input  logic        in_valid1,
  input  logic        in_last0,
  input  logic        in_last1,
  output logic        eng_en,
  output logic [31:0] eng_data_in,
  output logic [1:0]  eng_select,
  output logic        eng_valid_in,
  input  logic [31:0] eng_data_out,
  input  logic        eng_valid_out,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_id,
  output logic        done,
  output logic        err
);

  localparam int unsigned WORDS = KEY_WIDTH / 32;
  localparam int unsigned CW    = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      r_state;

  // grant bookkeeping
  logic [1:0]  r_gnt;
  logic        r_gidx;
  logic        r_rr;

  // engine-side registered outputs
  logic        r_eng_en;
  logic        r_eng_valid_in;
  logic [31:0] r_eng_data_in;
  logic [1:0]  r_eng_select;

  // requester-side registered outputs
  logic [31:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_id;
  logic        r_done;
  logic        r_err;

  // field tracking: type of last forwarded word and words forwarded in that field
  logic [1:0]  r_prev_sel;
  logic [CW-1:0] r_cnt;
  logic        r_ovf_seen;

  // single-word holding slot used across the GAP cycle
  logic [31:0] r_hold_data;
  logic [1:0]  r_hold_sel;
  logic        r_hold_last;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
`endif

  // granted requester's word, selected by the latched grant index
  logic        w_valid;
  logic [1:0]  w_sel;
  logic [31:0] w_data;
  logic        w_last;
  logic        w_pick;
  logic        w_type_chg;
  logic        w_field_full;

  // mux the granted requester's input port
  assign w_valid = r_gidx ? in_valid1 : in_valid0;
  assign w_sel   = r_gidx ? in_sel1   : in_sel0;
  assign w_data  = r_gidx ? in_data1  : in_data0;
  assign w_last  = r_gidx ? in_last1  : in_last0;

  // round-robin choice: pointer decides only when both requesters ask
  assign w_pick = (req == 2'b11) ? r_rr : req[1];

  // field boundary: first word of a job never counts as a change
  assign w_type_chg   = (r_prev_sel != 2'b00) && (w_sel != r_prev_sel);
  assign w_field_full = (r_cnt == CW'(WORDS));

  // job FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_gnt          <= 2'b00;
      r_gidx         <= 1'b0;
      r_rr           <= 1'b0;
      r_eng_en       <= 1'b0;
      r_eng_valid_in <= 1'b0;
      r_eng_data_in  <= 32'd0;
      r_eng_select   <= 2'b00;
      r_out_data     <= 32'd0;
      r_out_valid    <= 1'b0;
      r_out_id       <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_prev_sel     <= 2'b00;
      r_cnt          <= '0;
      r_ovf_seen     <= 1'b0;
      r_hold_data    <= 32'd0;
      r_hold_sel     <= 2'b00;
      r_hold_last    <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      r_tmo          <= '0;
`endif
    end else begin
      r_eng_en       <= 1'b1;
      r_eng_valid_in <= 1'b0;
      r_eng_data_in  <= 32'd0;
      r_eng_select   <= 2'b00;
      r_out_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      r_tmo          <= '0;
`endif

      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_gidx     <= w_pick;
            r_gnt      <= w_pick ? 2'b10 : 2'b01;
            r_rr       <= ~w_pick;
            r_prev_sel <= 2'b00;
            r_cnt      <= '0;
            r_ovf_seen <= 1'b0;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_valid) begin
            if (w_sel == 2'b00) begin
              // untyped words are discarded but still may end the job
              if (w_last) r_state <= S_WAIT;
            end else if (w_type_chg) begin
              // park the word; it goes out after the one-cycle field gap
              r_hold_data <= w_data;
              r_hold_sel  <= w_sel;
              r_hold_last <= w_last;
              r_prev_sel  <= w_sel;
              r_cnt       <= CW'(1);
              r_ovf_seen  <= 1'b0;
              r_state     <= S_GAP;
            end else if (w_field_full) begin
              // excess word in this field: drop it, flag the first such drop
              if (!r_ovf_seen) begin
                r_err      <= 1'b1;
                r_ovf_seen <= 1'b1;
              end
              if (w_last) r_state <= S_WAIT;
            end else begin
              r_eng_valid_in <= 1'b1;
              r_eng_data_in  <= w_data;
              r_eng_select   <= w_sel;
              r_prev_sel     <= w_sel;
              r_cnt          <= r_cnt + CW'(1);
              if (w_last) r_state <= S_WAIT;
            end
          end
        end

        S_GAP: begin
          // requester words presented during the gap are not captured
          r_eng_valid_in <= 1'b1;
          r_eng_data_in  <= r_hold_data;
          r_eng_select   <= r_hold_sel;
          r_state        <= r_hold_last ? S_WAIT : S_LOAD;
        end

        S_WAIT: begin
          if (eng_valid_out) begin
            r_out_valid <= 1'b1;
            r_out_data  <= eng_data_out;
            r_out_id    <= r_gidx;
            r_state     <= S_DRAIN;
          end
`ifdef RSA_ARB_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
`endif
        end

        S_DRAIN: begin
          if (eng_valid_out) begin
            r_out_valid <= 1'b1;
            r_out_data  <= eng_data_out;
            r_out_id    <= r_gidx;
          end else begin
            r_done  <= 1'b1;
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign eng_en       = r_eng_en;
  assign eng_valid_in = r_eng_valid_in;
  assign eng_data_in  = r_eng_data_in;
  assign eng_select   = r_eng_select;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_id       = r_out_id;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Self-checking bench for rsa_job_arbiter: a directed job table, corner-case
// sequences, and randomized jobs checked against a word-list reference model.
`timescale 1ns/1ps
module tb_rsa_job_arbiter;

  localparam int KW    = 256;
  localparam int WORDS = KW / 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [31:0] in_data0, in_data1;
  logic [1:0]  in_sel0, in_sel1;
  logic        in_valid0, in_valid1, in_last0, in_last1;
  logic        eng_en;
  logic [31:0] eng_data_in;
  logic [1:0]  eng_select;
  logic        eng_valid_in;
  logic [31:0] eng_data_out;
  logic        eng_valid_out;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_id;
  logic        done;
  logic        err;

  rsa_job_arbiter #(.KEY_WIDTH(KW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_sel0(in_sel0), .in_sel1(in_sel1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_last0(in_last0), .in_last1(in_last1),
    .eng_en(eng_en), .eng_data_in(eng_data_in), .eng_select(eng_select),
    .eng_valid_in(eng_valid_in), .eng_data_out(eng_data_out),
    .eng_valid_out(eng_valid_out), .out_data(out_data), .out_valid(out_valid),
    .out_id(out_id), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // observed traffic, appended at each falling edge
  logic [33:0] eng_q[$];
  logic [32:0] out_q[$];
  int err_cnt  = 0;
  int done_cnt = 0;
  int idle_bad = 0;
  int gnt_bad  = 0;

  always @(negedge clk) begin
    if (eng_valid_in) eng_q.push_back({eng_select, eng_data_in});
    if (!eng_valid_in && (eng_data_in != 32'd0)) idle_bad++;
    if (out_valid) out_q.push_back({out_id, out_data});
    if (err) err_cnt++;
    if (done) done_cnt++;
    if (gnt == 2'b11) gnt_bad++;
  end

  // current job and its expected forwarded word list
  logic [1:0]  job_sel[$];
  logic [31:0] job_dat[$];
  logic [33:0] exp_fwd[$];
  logic        last_g = 1'b1;

  typedef struct {
    logic [1:0]  rq;
    int          n_mod;
    int          n_key;
    int          n_dat;
    logic        exp_id;
    int          exp_err;
    int          exp_nfwd;
    bit          modexp;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modpow(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    logic [63:0] r, x;
    if (m == 32'd0) return 32'd0;
    r = 64'd1 % 64'(m);
    x = 64'(b % m);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[31:0];
  endfunction

  // reference: which words the engine should see and how many overflow errors
  task automatic model_fwd(output int e_err);
    logic [1:0] cur;
    int cnt;
    bit ovf;
    exp_fwd.delete();
    cur = 2'b00; cnt = 0; ovf = 0; e_err = 0;
    for (int i = 0; i < job_sel.size(); i++) begin
      if (job_sel[i] == 2'b00) continue;
      if (job_sel[i] != cur) begin
        cur = job_sel[i]; cnt = 1; ovf = 0;
        exp_fwd.push_back({cur, job_dat[i]});
      end else if (cnt < WORDS) begin
        cnt++;
        exp_fwd.push_back({cur, job_dat[i]});
      end else if (!ovf) begin
        e_err++; ovf = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid0 = 1'b0; in_sel0 = 2'b00; in_data0 = 32'd0; in_last0 = 1'b0;
    in_valid1 = 1'b0; in_sel1 = 2'b00; in_data1 = 32'd0; in_last1 = 1'b0;
  endtask

  // drive the granted port; the other port carries random noise
  task automatic set_inputs(input logic g, input logic v, input logic [1:0] s,
                            input logic [31:0] d, input logic l);
    if (g) begin
      in_valid1 = v; in_sel1 = s; in_data1 = d; in_last1 = l;
      in_valid0 = 1'($urandom_range(0, 1)); in_sel0 = 2'($urandom);
      in_data0 = $urandom; in_last0 = 1'($urandom_range(0, 1));
    end else begin
      in_valid0 = v; in_sel0 = s; in_data0 = d; in_last0 = l;
      in_valid1 = 1'($urandom_range(0, 1)); in_sel1 = 2'($urandom);
      in_data1 = $urandom; in_last1 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load_words(input int nm, input int nk, input int nd);
    job_sel.delete(); job_dat.delete();
    repeat (nm) begin job_sel.push_back(2'b01); job_dat.push_back(32'h0000000D); end
    repeat (nk) begin job_sel.push_back(2'b10); job_dat.push_back(32'h00000005); end
    repeat (nd) begin job_sel.push_back(2'b11); job_dat.push_back(32'h00000002); end
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (gnt == 2'b00 && k < 20) begin cyc(); k++; end
  endtask

  task automatic run_job(input logic [1:0] rq, input logic exp_id, input int exp_e,
                         input int exp_n, input bit modexp, input logic [31:0] exp_res);
    int eb, ob, errb, doneb, k, dummy;
    logic g;
    logic [1:0] prev_nz;
    logic [31:0] res[$];
    logic [31:0] m, e, d;
    model_fwd(dummy);
    eb = eng_q.size(); ob = out_q.size(); errb = err_cnt; doneb = done_cnt;
    req = rq;
    wait_grant();
    chk("grant", 64'(gnt), exp_id ? 64'd2 : 64'd1);
    last_g = exp_id;
    req = 2'b00;
    if (gnt == 2'b00) return;
    g = gnt[1];
    prev_nz = 2'b00;
    for (int i = 0; i < job_sel.size(); i++) begin
      set_inputs(g, 1'b1, job_sel[i], job_dat[i], i == job_sel.size() - 1);
      cyc();
      if (job_sel[i] != 2'b00 && job_sel[i] != prev_nz) begin
        set_inputs(g, 1'b0, 2'b00, 32'd0, 1'b0); cyc();
      end
      if (job_sel[i] != 2'b00) prev_nz = job_sel[i];
      if ($urandom_range(0, 3) == 0) begin set_inputs(g, 1'b0, 2'b00, 32'd0, 1'b0); cyc(); end
    end
    idle_inputs();
    repeat (3) cyc();
    // act as the engine
    if (modexp) begin
      m = 32'd0; e = 32'd0; d = 32'd0;
      for (int i = eb; i < eng_q.size(); i++) begin
        case (eng_q[i][33:32])
          2'b01: m = eng_q[i][31:0];
          2'b10: e = eng_q[i][31:0];
          2'b11: d = eng_q[i][31:0];
          default: ;
        endcase
      end
      res.push_back(modpow(d, e, m));
    end else begin
      repeat ($urandom_range(1, 4)) res.push_back($urandom);
    end
    foreach (res[i]) begin
      eng_valid_out = 1'b1; eng_data_out = res[i]; cyc();
    end
    eng_valid_out = 1'b0; eng_data_out = $urandom;
    k = 0;
    while (done_cnt == doneb && k < 20) begin @(negedge clk); #1; k++; end
    chk("done_pulse", 64'(done_cnt - doneb), 64'd1);
    chk("gnt_cleared", 64'(gnt), 64'd0);
    cyc();
    chk("fwd_count", 64'(eng_q.size() - eb), 64'(exp_n));
    for (int i = 0; i < exp_fwd.size() && eb + i < eng_q.size(); i++)
      chk("fwd_word", 64'(eng_q[eb + i]), 64'(exp_fwd[i]));
    chk("out_count", 64'(out_q.size() - ob), 64'(res.size()));
    for (int i = 0; i < res.size() && ob + i < out_q.size(); i++)
      chk("out_word", 64'(out_q[ob + i]), 64'({exp_id, res[i]}));
    if (modexp && out_q.size() > ob)
      chk("result", 64'(out_q[ob][31:0]), 64'(exp_res));
    chk("err_pulses", 64'(err_cnt - errb), 64'(exp_e));
    chk("eng_en", 64'(eng_en), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, doneb, errb, ob, e_err;
    logic [1:0] rq;
    logic eid;

    vecs[0] = '{2'b11, 1, 1, 1, 1'b0, 0, 3, 1'b1, 32'h00000006};
    vecs[1] = '{2'b11, 1, 1, 1, 1'b1, 0, 3, 1'b1, 32'h00000006};
    vecs[2] = '{2'b01, 9, 1, 1, 1'b0, 1, 10, 1'b1, 32'h00000006};
    vecs[3] = '{2'b10, 0, 0, 3, 1'b1, 0, 3, 1'b0, 32'h00000000};
    vecs[4] = '{2'b11, 1, 10, 1, 1'b0, 1, 10, 1'b1, 32'h00000006};

    rst = 1'b1; req = 2'b00; eng_valid_out = 1'b0; eng_data_out = 32'd0;
    idle_inputs();
    repeat (2) cyc();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_eng_en", 64'(eng_en), 64'd0);
    chk("rst_eng_valid_in", 64'(eng_valid_in), 64'd0);
    chk("rst_eng_select", 64'(eng_select), 64'd0);
    chk("rst_eng_data_in", 64'(eng_data_in), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    repeat (2) cyc();
    chk("eng_en_after_rst", 64'(eng_en), 64'd1);

    // directed table
    for (int v = 0; v < 5; v++) begin
      load_words(vecs[v].n_mod, vecs[v].n_key, vecs[v].n_dat);
      run_job(vecs[v].rq, vecs[v].exp_id, vecs[v].exp_err, vecs[v].exp_nfwd,
              vecs[v].modexp, vecs[v].exp_res);
    end

    // data-only job left waiting on a silent engine
    doneb = done_cnt; errb = err_cnt;
    req = 2'b01;
    wait_grant();
    chk("wait_grant", 64'(gnt), 64'd1);
    last_g = 1'b0;
    req = 2'b00;
    set_inputs(1'b0, 1'b1, 2'b11, $urandom, 1'b0); cyc();
    set_inputs(1'b0, 1'b1, 2'b11, $urandom, 1'b1); cyc();
    idle_inputs();
`ifdef RSA_ARB_TIMEOUT_EN
    k = 0;
    while (!err && k < 40) begin cyc(); k++; end
    chk("tmo_latency", 64'(k), 64'd16);
    chk("tmo_done", 64'(done), 64'd1);
    chk("tmo_gnt", 64'(gnt), 64'd0);
    cyc();
    chk("tmo_err_once", 64'(err_cnt - errb), 64'd1);
`else
    repeat (40) cyc();
    chk("no_timeout_done", 64'(done_cnt - doneb), 64'd0);
    chk("still_granted", 64'(gnt), 64'd1);
    eng_valid_out = 1'b1; eng_data_out = 32'h0BADF00D; cyc();
    eng_valid_out = 1'b0; eng_data_out = 32'd0;
    k = 0;
    while (done_cnt == doneb && k < 20) begin cyc(); k++; end
    chk("late_result_done", 64'(done_cnt - doneb), 64'd1);
    chk("late_result_data", 64'(out_q[out_q.size() - 1]), 64'({1'b0, 32'h0BADF00D}));
    chk("late_no_err", 64'(err_cnt - errb), 64'd0);
`endif

    // randomized jobs against the reference model
    for (int j = 0; j < 40; j++) begin
      logic [1:0] cur;
      rq = 2'($urandom_range(1, 3));
      eid = (rq == 2'b11) ? ~last_g : rq[1];
      job_sel.delete(); job_dat.delete();
      cur = 2'($urandom);
      repeat ($urandom_range(1, 14)) begin
        if ($urandom_range(0, 9) < 3) cur = 2'($urandom);
        job_sel.push_back(cur);
        job_dat.push_back($urandom);
      end
      model_fwd(e_err);
      run_job(rq, eid, e_err, exp_fwd.size(), 1'b0, 32'd0);
    end

    // reset in the middle of a load
    doneb = done_cnt;
    req = 2'b10;
    wait_grant();
    req = 2'b00;
    set_inputs(1'b1, 1'b1, 2'b01, 32'h12345678, 1'b0); cyc();
    set_inputs(1'b1, 1'b1, 2'b10, 32'h9ABCDEF0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_eng_en", 64'(eng_en), 64'd0);
    chk("mid_rst_eng_valid_in", 64'(eng_valid_in), 64'd0);
    chk("mid_rst_eng_data_in", 64'(eng_data_in), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    idle_inputs();
    cyc();
    rst = 1'b0;
    ob = out_q.size();
    eng_valid_out = 1'b1; eng_data_out = 32'hFEEDBEEF;
    repeat (2) cyc();
    eng_valid_out = 1'b0; eng_data_out = 32'd0;
    repeat (2) cyc();
    chk("post_rst_out_ignored", 64'(out_q.size() - ob), 64'd0);
    chk("post_rst_no_done", 64'(done_cnt - doneb), 64'd0);
    last_g = 1'b1;
    load_words(1, 1, 1);
    run_job(2'b11, 1'b0, 0, 3, 1'b1, 32'h00000006);

    chk("idle_data_zero", 64'(idle_bad), 64'd0);
    chk("gnt_onehot", 64'(gnt_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
